// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-request main memory.
// One transaction is in flight at a time; every output is registered.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // Port 0
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    // Port 1
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    // Main memory
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e state_q, state_d;

    // last_grant: 1 means port 1 was served most recently
    logic last_grant_q, last_grant_d;
    // owner: port currently holding the memory (1 = port 1)
    logic owner_q, owner_d;

    logic              m0_gnt_d, m1_gnt_d;
    logic              m0_done_d, m1_done_d;
    logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    // Round-robin pick: a lone requester wins; on contention the port not served last wins
    logic win;
    assign win = (m0_req && m1_req) ? ~last_grant_q : m1_req;

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            m0_gnt       <= 1'b0;
            m1_gnt       <= 1'b0;
            m0_done      <= 1'b0;
            m1_done      <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            m0_gnt       <= m0_gnt_d;
            m1_gnt       <= m1_gnt_d;
            m0_done      <= m0_done_d;
            m1_done      <= m1_done_d;
            m0_rdata     <= m0_rdata_d;
            m1_rdata     <= m1_rdata_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (m0_req || m1_req) state_d = StIssue;
            StIssue: if (mem_ready)        state_d = StWait;
            StWait:  if (mem_done)         state_d = StDone;
            StDone:                        state_d = StIdle;
            default:                       state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and bookkeeping
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        m0_gnt_d     = m0_gnt;
        m1_gnt_d     = m1_gnt;
        m0_done_d    = m0_done;
        m1_done_d    = m1_done;
        m0_rdata_d   = m0_rdata;
        m1_rdata_d   = m1_rdata;
        mem_req_d    = mem_req;
        // Command fields hold from the grant through DONE; memory samples them at completion
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    owner_d     = win;
                    mem_req_d   = 1'b1;
                    m0_gnt_d    = ~win;
                    m1_gnt_d    = win;
                    mem_we_d    = win ? m1_we    : m0_we;
                    mem_addr_d  = win ? m1_addr  : m0_addr;
                    mem_wdata_d = win ? m1_wdata : m0_wdata;
                end
            end
            StIssue: begin
                if (mem_ready) mem_req_d = 1'b0;
            end
            StWait: begin
                if (mem_done) begin
                    if (owner_q) begin
                        m1_done_d = 1'b1;
                        if (!mem_we) m1_rdata_d = mem_rdata;
                    end else begin
                        m0_done_d = 1'b1;
                        if (!mem_we) m0_rdata_d = mem_rdata;
                    end
                end
            end
            StDone: begin
                m0_done_d    = 1'b0;
                m1_done_d    = 1'b0;
                m0_gnt_d     = 1'b0;
                m1_gnt_d     = 1'b0;
                last_grant_d = owner_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m0_req  input  1  port 0 transaction request, held until m0_done.
REQ-006 m0_we  input  1  port 0 write enable (1 = write, 0 = read).
REQ-007 m0_addr  input  ADDR_W  port 0 word address.
REQ-008 m0_wdata  input  DATA_W  port 0 write data.
REQ-009 m0_gnt  output  1  port 0 owns the memory (states ISSUE, WAIT, DONE).
REQ-010 m0_done  output  1  one-cycle completion pulse for port 0.
REQ-011 m0_rdata  output  DATA_W  port 0 read data, valid with m0_done, held until next port 0 completion.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: same directions, widths and meanings as port 0, for port 1.
REQ-013 mem_req  output  1  request to main memory.
REQ-014 mem_we  output  1  write enable to main memory.
REQ-015 mem_addr  output  ADDR_W  address to main memory.
REQ-016 mem_wdata  output  DATA_W  write data to main memory.
REQ-017 mem_ready  input  1  memory idle; a request is accepted on an edge where mem_req and mem_ready are both 1.
REQ-018 mem_done  input  1  one-cycle memory completion pulse; mem_rdata is valid in the same cycle.
REQ-019 mem_rdata  input  DATA_W  memory read data.

Function
REQ-020 All outputs shall be registered.
REQ-021 The FSM shall have four states: IDLE, ISSUE, WAIT and DONE.
REQ-022 IDLE: if either mX_req is 1, select the winner, latch its we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_req=1 and the winner's gnt=1, and go to ISSUE; otherwise stay in IDLE.
REQ-023 Arbitration shall be round-robin: when both ports request, the port not granted last wins; a single requester always wins.
REQ-024 ISSUE: mem_req stays 1 until an edge samples mem_ready=1; at that edge mem_req goes to 0 and the FSM goes to WAIT.
REQ-025 WAIT: on an edge that samples mem_done=1, load the owner's rdata from mem_rdata (reads only; writes leave it unchanged), set the owner's done=1 and go to DONE.
REQ-026 DONE lasts exactly one cycle with done=1 and no arbitration; the next edge clears done and gnt, updates last_grant to the owner and returns to IDLE.
REQ-027 mem_we, mem_addr and mem_wdata shall stay stable from the latch in IDLE through the end of DONE, because memory samples addr/wdata at completion time.
REQ-028 Requests are not queued; an mX_req arriving while the other port owns the memory waits, unserviced, until IDLE.
REQ-029 Requester-side latency: with memory LATENCY=L and mem_ready=1, mX_done is high in the cycle after the L+3rd edge following the IDLE grant edge.
REQ-030 A requester deasserting mX_req mid-transaction shall not abort it; the transaction completes and done still pulses.
REQ-031 A mem_done sampled in IDLE, ISSUE or DONE shall be ignored.
REQ-032 At most one mX_gnt and at most one mX_done shall be high in any cycle.

Reset
REQ-033 On rst=1, state goes to IDLE, last_grant goes to port 1 (port 0 has first priority), and all outputs go to 0, including rdata and mem_addr/mem_wdata.
REQ-034 Reset mid-transaction shall abandon it with no done pulse; a stale mem_done after reset is ignored per REQ-031.

Verification
REQ-035 Port 0 read of addr 0x0010, memory L=8, port 1 idle -> m0_done after edge 11, m0_rdata=0x00000010, m1_done never asserted.
REQ-036 Both ports request reads (0x0005, 0x0006) simultaneously after reset -> port 0 served first (rdata 5), then port 1 (rdata 6); gnt never overlaps.
REQ-037 Both ports request continuously for 4 transactions -> grant sequence 0,1,0,1.
REQ-038 Port 1 writes 0xDEADBEEF to 0x0100, then port 0 reads 0x0100 -> m0_rdata=0xDEADBEEF, m1_rdata unchanged by the write.
REQ-039 Hold mem_ready=0 for 5 cycles during ISSUE -> mem_req stays 1 and the address stays stable; acceptance occurs on the first edge with mem_ready=1.
REQ-040 Assert rst during WAIT -> all outputs 0 immediately, no done pulse; the following mem_done is ignored and the next request is served normally.
